// File: rtl/irq_controller.sv
// Interrupt controller: latches peripheral IRQs into PENDING, masks them with ENABLE, and presents the
// lowest-index request to the CPU through a req/ack/EOI handshake. `define IRQC_EDGE_EN for edge capture.
module irq_controller #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_SOURCES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   write_enable,
   output logic [DATA_WIDTH-1:0]  data_out,
   input  logic [NUM_SOURCES-1:0] irq_in,
   output logic                   cpu_irq,
   input  logic                   cpu_ack,
   output logic [4:0]             cpu_irq_id
);

   localparam int unsigned IdWidth = 5;

   localparam logic [ADDR_WIDTH-1:0] AddrPending = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] AddrEnable  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] AddrActive  = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] AddrEoi     = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] AddrRaw     = ADDR_WIDTH'(4);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [NUM_SOURCES-1:0] pending_q, pending_d;
   logic [NUM_SOURCES-1:0] enable_q, enable_d;
   logic [IdWidth-1:0]     irq_id_q, irq_id_d;
   logic                   cpu_irq_q, cpu_irq_d;

   logic [NUM_SOURCES-1:0] set_c;
   logic [NUM_SOURCES-1:0] pend_en_c;
   logic [NUM_SOURCES-1:0] claim_mask_c;
   logic [IdWidth-1:0]     claim_idx_c;
   logic                   claim_c;
   logic                   we_pending_c;
   logic                   we_enable_c;
   logic                   we_eoi_c;
   logic                   in_service_c;
   logic                   unused_c;

   assign unused_c = ^data_in;

`ifdef IRQC_EDGE_EN
   logic [NUM_SOURCES-1:0] irq_in_q;

   // History cleared in reset so a line already high at release still yields one event
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_in_q <= '0;
      end else begin
         irq_in_q <= irq_in;
      end
   end

   assign set_c = irq_in & ~irq_in_q;
`else
   assign set_c = irq_in;
`endif

   assign pend_en_c    = pending_q & enable_q;
   assign we_pending_c = write_enable && (addr == AddrPending);
   assign we_enable_c  = write_enable && (addr == AddrEnable);
   assign we_eoi_c     = write_enable && (addr == AddrEoi);
   assign in_service_c = (state_q == ST_SERVICE);

   // Lowest set index of the enabled pending vector wins
   always_comb begin
      claim_idx_c  = '0;
      claim_mask_c = '0;
      for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
         if (pend_en_c[i]) begin
            claim_idx_c     = IdWidth'(i);
            claim_mask_c    = '0;
            claim_mask_c[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      claim_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|pend_en_c) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (cpu_ack && (|pend_en_c)) begin
               state_d  = ST_SERVICE;
               irq_id_d = claim_idx_c;
               claim_c  = 1'b1;
            end else if (!(|pend_en_c)) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (we_eoi_c) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      cpu_irq_d = (state_d == ST_REQ);

      // New sets are applied last so a same-cycle clear never loses an event
      pending_d = pending_q;
      if (we_pending_c) pending_d = pending_d & ~data_in[NUM_SOURCES-1:0];
      if (claim_c)      pending_d = pending_d & ~claim_mask_c;
      pending_d = pending_d | set_c;

      enable_d = enable_q;
      if (we_enable_c) enable_d = data_in[NUM_SOURCES-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         enable_q  <= '0;
         irq_id_q  <= '0;
         cpu_irq_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         irq_id_q  <= irq_id_d;
         cpu_irq_q <= cpu_irq_d;
      end
   end

   // Register read mux
   always_comb begin
      data_out = '0;
      case (addr)
         AddrPending: data_out = DATA_WIDTH'(pending_q);
         AddrEnable:  data_out = DATA_WIDTH'(enable_q);
         AddrActive: begin
            data_out[DATA_WIDTH-1]  = in_service_c;
            data_out[IdWidth-1:0]   = irq_id_q;
         end
         AddrRaw:     data_out = DATA_WIDTH'(irq_in);
         default:     data_out = '0;
      endcase
   end

   assign cpu_irq    = cpu_irq_q;
   assign cpu_irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed vector table, hand sequences, and a randomized run
// against a bitmask-level reference model.
module tb_irq_controller;

   localparam int unsigned MASK = 32'hF;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  addr;
   logic [31:0] data_in;
   logic        write_enable;
   logic [31:0] data_out;
   logic [3:0]  irq_in;
   logic        cpu_irq;
   logic        cpu_ack;
   logic [4:0]  cpu_irq_id;

   int n_tests = 0;
   int n_fail  = 0;

   irq_controller #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_SOURCES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .addr         (addr),
      .data_in      (data_in),
      .write_enable (write_enable),
      .data_out     (data_out),
      .irq_in       (irq_in),
      .cpu_irq      (cpu_irq),
      .cpu_ack      (cpu_ack),
      .cpu_irq_id   (cpu_irq_id)
   );

   always #5 clk = ~clk;

   // Reference model: whole-register bitmasks plus two flags for "requesting" and "in service"
   int unsigned m_pend, m_en, m_id, m_prev;
   bit          m_req, m_svc;

   task automatic model_step();
      int unsigned set, pe, np;
      bit nreq, nsvc;
      if (rst) begin
         m_pend = 0; m_en = 0; m_id = 0; m_prev = 0; m_req = 0; m_svc = 0;
         return;
      end
`ifdef IRQC_EDGE_EN
      set = 32'(irq_in) & ~m_prev;
`else
      set = 32'(irq_in);
`endif
      m_prev = 32'(irq_in);
      pe   = m_pend & m_en;
      np   = m_pend;
      nreq = m_req;
      nsvc = m_svc;
      if (write_enable && addr == 4'd0) np = np & ~data_in;
      if (write_enable && addr == 4'd1) m_en = data_in & MASK;
      if (!m_req && !m_svc) begin
         nreq = (pe != 0);
      end else if (m_req) begin
         if (cpu_ack && pe != 0) begin
            m_id = $clog2(pe & (~pe + 1));
            np   = np & ~(32'd1 << m_id);
            nreq = 0;
            nsvc = 1;
         end else if (pe == 0) begin
            nreq = 0;
         end
      end else if (write_enable && addr == 4'd3) begin
         nsvc = 0;
      end
      m_pend = (np | set) & MASK;
      m_req  = nreq;
      m_svc  = nsvc;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] a);
      case (a)
         4'd0:    return m_pend;
         4'd1:    return m_en;
         4'd2:    return (32'(m_svc) << 31) | m_id;
         4'd4:    return 32'(irq_in);
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      write_enable = 1'b0;
      cpu_ack      = 1'b0;
      data_in      = '0;
      addr         = 4'd0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      addr = a; data_in = d; write_enable = 1'b1;
      tick();
      idle();
   endtask

   task automatic wait_irq(input string name);
      for (int k = 0; k < 10 && cpu_irq !== 1'b1; k++) tick();
      check(name, 32'(cpu_irq), 32'd1);
   endtask

   task automatic read_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(name, data_out, exp);
   endtask

   typedef struct {
      logic [3:0]  irq;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] din;
      logic        ack;
      logic        exp_irq;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[19];

   initial begin
      // Flow 1 (source 1), flow 3 (masked source 3), same-cycle set/clear on source 0
      vecs[0]  = '{4'h0, 1'b1, 4'h1, 32'h3, 1'b0, 1'b0, 32'h3};
      vecs[1]  = '{4'h2, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h2};
      vecs[2]  = '{4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h2};
      vecs[3]  = '{4'h0, 1'b0, 4'h2, 32'h0, 1'b1, 1'b0, 32'h80000001};
      vecs[4]  = '{4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{4'h0, 1'b1, 4'h3, 32'h0, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{4'h0, 1'b0, 4'h2, 32'h0, 1'b0, 1'b0, 32'h1};
      vecs[7]  = '{4'h0, 1'b1, 4'h1, 32'h0, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{4'h8, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h8};
      vecs[9]  = '{4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h8};
      vecs[10] = '{4'h0, 1'b1, 4'h1, 32'h8, 1'b0, 1'b0, 32'h8};
      vecs[11] = '{4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h8};
      vecs[12] = '{4'h0, 1'b1, 4'h0, 32'h8, 1'b0, 1'b1, 32'h0};
      vecs[13] = '{4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vecs[14] = '{4'h0, 1'b1, 4'h1, 32'h1, 1'b0, 1'b0, 32'h1};
      vecs[15] = '{4'h1, 1'b1, 4'h0, 32'h1, 1'b0, 1'b0, 32'h1};
      vecs[16] = '{4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1};
      vecs[17] = '{4'h0, 1'b0, 4'h2, 32'h0, 1'b1, 1'b0, 32'h80000000};
      vecs[18] = '{4'h0, 1'b1, 4'h3, 32'h0, 1'b0, 1'b0, 32'h0};

      rst = 1'b1; irq_in = '0;
      idle();
      tick(); tick();
      rst = 1'b0;

      check("reset_cpu_irq", 32'(cpu_irq), 32'd0);
      check("reset_irq_id", 32'(cpu_irq_id), 32'd0);
      read_chk("reset_pending", 4'd0, 32'd0);
      read_chk("reset_enable", 4'd1, 32'd0);
      read_chk("reset_active", 4'd2, 32'd0);

      for (int i = 0; i < 19; i++) begin
         irq_in = vecs[i].irq; write_enable = vecs[i].we; addr = vecs[i].addr;
         data_in = vecs[i].din; cpu_ack = vecs[i].ack;
         tick();
         check($sformatf("vec%0d_irq", i), 32'(cpu_irq), 32'(vecs[i].exp_irq));
         check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
         irq_in = '0;
         idle();
      end

      // Two simultaneous sources served in priority order
      wr(4'd1, 32'h5);
      irq_in = 4'h5; tick(); irq_in = '0;
      wait_irq("t2_req1");
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      check("t2_id0", 32'(cpu_irq_id), 32'd0);
      check("t2_irq_low", 32'(cpu_irq), 32'd0);
      wr(4'd3, 32'h0);
      wait_irq("t2_req2");
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      check("t2_id2", 32'(cpu_irq_id), 32'd2);
      read_chk("t2_active", 4'd2, 32'h80000002);
      wr(4'd3, 32'h0);

      // Reset while in service
      wr(4'd1, 32'h1);
      irq_in = 4'h1; tick(); irq_in = '0;
      wait_irq("t5_req");
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      read_chk("t5_in_service", 4'd2, 32'h80000000);
      irq_in = 4'h2; rst = 1'b1; tick(); rst = 1'b0; irq_in = '0;
      check("t5_cpu_irq", 32'(cpu_irq), 32'd0);
      read_chk("t5_active", 4'd2, 32'd0);
      read_chk("t5_pending", 4'd0, 32'd0);
      read_chk("t5_enable", 4'd1, 32'd0);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      check("t5_ack_ignored_irq", 32'(cpu_irq), 32'd0);
      read_chk("t5_ack_ignored_active", 4'd2, 32'd0);

      // Line held high across claim and EOI
      begin
         bit seen;
         wr(4'd1, 32'h2);
         irq_in = 4'h2;
         tick(); tick();
         check("t6_req", 32'(cpu_irq), 32'd1);
         cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
         check("t6_claim_id", 32'(cpu_irq_id), 32'd1);
         wr(4'd3, 32'h0);
         seen = 1'b0;
         for (int k = 0; k < 2; k++) begin
            tick();
            if (cpu_irq === 1'b1) seen = 1'b1;
         end
`ifdef IRQC_EDGE_EN
         check("t6_no_rerequest", 32'(seen), 32'd0);
`else
         check("t6_rerequest", 32'(seen), 32'd1);
`endif
         for (int k = 0; k < 14; k++) tick();
`ifdef IRQC_EDGE_EN
         check("t6_held_quiet", 32'(cpu_irq), 32'd0);
`endif
         irq_in = '0;
         rst = 1'b1; tick(); rst = 1'b0;
      end

      // Randomized run against the reference model
      for (int n = 0; n < 600; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         irq_in       = 4'($urandom & $urandom);
         write_enable = ($urandom_range(0, 9) < 3);
         addr         = 4'($urandom_range(0, 5));
         data_in      = $urandom;
         cpu_ack      = ($urandom_range(0, 9) < 3);
         tick();
         check("rnd_cpu_irq", 32'(cpu_irq), 32'(m_req));
         check("rnd_irq_id", 32'(cpu_irq_id), m_id);
         check("rnd_data_out", data_out, m_read(addr));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
